// File: rtl/uex_mem_access_pkg.sv
// Shared types and lane helpers for the uex memory-access path.
// The lane functions are plain automatic functions so an initiator-side
// model can reuse exactly the same byte-lane arithmetic as the responder.
package uex_mem_access_pkg;

    typedef enum logic [1:0] {
        SZ8   = 2'd0,
        SZ16  = 2'd1,
        SZ32  = 2'd2,
        SZRSV = 2'd3
    } uex_mem_size_e;

    typedef struct packed {
        logic [31:0] rdata;
        logic        err;
        logic        write;
    } uex_mem_rsp_t;

    // Byte-enable style mask for an access of the given size at byte offset off.
    function automatic logic [31:0] uex_lane_mask(uex_mem_size_e size, logic [1:0] off);
        logic [31:0] base;
        case (size)
            SZ8:     base = 32'h0000_00FF;
            SZ16:    base = 32'h0000_FFFF;
            SZ32:    base = 32'hFFFF_FFFF;
            default: base = 32'h0000_0000;
        endcase
        return base << {off, 3'b000};
    endfunction

    // Right-justify the addressed bytes of a storage word, zero-extending.
    function automatic logic [31:0] uex_lane_extract(logic [31:0] word, uex_mem_size_e size,
                                                     logic [1:0] off);
        logic [31:0] shifted;
        logic [31:0] result;
        shifted = word >> {off, 3'b000};
        case (size)
            SZ8:     result = {24'h00_0000, shifted[7:0]};
            SZ16:    result = {16'h0000, shifted[15:0]};
            SZ32:    result = shifted;
            default: result = 32'h0000_0000;
        endcase
        return result;
    endfunction

    // Merge right-justified write data into the addressed lanes of a word.
    function automatic logic [31:0] uex_lane_insert(logic [31:0] word, logic [31:0] wdata,
                                                    uex_mem_size_e size, logic [1:0] off);
        logic [31:0] mask;
        mask = uex_lane_mask(size, off);
        return (word & ~mask) | ((wdata << {off, 3'b000}) & mask);
    endfunction

    // Alignment/size legality; the reserved size is always illegal.
    function automatic logic uex_bad_align(uex_mem_size_e size, logic [1:0] off);
        logic bad;
        case (size)
            SZ8:     bad = 1'b0;
            SZ16:    bad = off[0];
            SZ32:    bad = (off != 2'b00);
            default: bad = 1'b1;
        endcase
        return bad;
    endfunction

endpackage

// File: rtl/uex_rsp_fifo.sv
// Synchronous response FIFO for the uex memory responder.
// Pointers and occupancy are reset; payload storage is not, because the
// head is only observed while the FIFO reports a non-zero count.
module uex_rsp_fifo
    import uex_mem_access_pkg::*;
#(
    parameter int DEPTH = 4,
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1,
    localparam int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               push,
    input  uex_mem_rsp_t       push_data,
    input  logic               pop,
    output uex_mem_rsp_t       head,
    output logic [CNT_W-1:0]   count
);

    uex_mem_rsp_t     mem_r [DEPTH];
    logic [PTR_W-1:0] wr_ptr_r;
    logic [PTR_W-1:0] rd_ptr_r;
    logic [CNT_W-1:0] count_r;
    logic             push_ok_s;
    logic             pop_ok_s;

    // Pointer wrap that also works for non-power-of-two depths.
    function automatic logic [PTR_W-1:0] next_ptr(logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? PTR_W'(0) : p + PTR_W'(1);
    endfunction

    // Qualify push/pop so an overflow or underflow can never corrupt state.
    always_comb begin
        pop_ok_s  = pop && (count_r != CNT_W'(0));
        push_ok_s = push && ((count_r != CNT_W'(DEPTH)) || pop_ok_s);
    end

    // Pointer and occupancy bookkeeping; a simultaneous push and pop keeps the count.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            wr_ptr_r <= PTR_W'(0);
            rd_ptr_r <= PTR_W'(0);
            count_r  <= CNT_W'(0);
        end else begin
            if (push_ok_s) begin
                wr_ptr_r <= next_ptr(wr_ptr_r);
            end
            if (pop_ok_s) begin
                rd_ptr_r <= next_ptr(rd_ptr_r);
            end
            case ({push_ok_s, pop_ok_s})
                2'b10:   count_r <= count_r + CNT_W'(1);
                2'b01:   count_r <= count_r - CNT_W'(1);
                default: count_r <= count_r;
            endcase
        end
    end

    // Payload write port.
    always_ff @(posedge clock) begin
        if (push_ok_s) begin
            mem_r[wr_ptr_r] <= push_data;
        end
    end

    assign head  = mem_r[rd_ptr_r];
    assign count = count_r;

endmodule

// File: rtl/uex_mem_access_responder.sv
// Target end of the uex memory path: accepts read/write requests, services
// them against a word-addressed storage array in a two-stage pipeline and
// returns one in-order response per request through a small FIFO.
// req_ready is issued against credits (FIFO occupancy plus the request in
// stage A) so a request is only accepted when its response is sure to fit.
module uex_mem_access_responder
    import uex_mem_access_pkg::*;
#(
    parameter int ADDR_W    = 16,
    parameter int DEPTH     = 1024,
    parameter int RSP_DEPTH = 4
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_write,
    input  logic [1:0]        req_size,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [31:0]       req_wdata,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [31:0]       rsp_rdata,
    output logic              rsp_err,
    output logic              rsp_write
);

    localparam int IDX_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(RSP_DEPTH + 1);

    // Stage A: registered request.
    logic              a_valid_r;
    logic              a_write_r;
    uex_mem_size_e     a_size_r;
    logic [ADDR_W-1:0] a_addr_r;
    logic [31:0]       a_wdata_r;

    logic              req_ready_r;
    logic              accept_s;

    // Stage B decode and storage access.
    logic [1:0]        off_s;
    logic [ADDR_W-3:0] word_idx_s;
    logic [IDX_W-1:0]  mem_idx_s;
    logic              oor_s;
    logic              err_s;
    logic              wr_en_s;
    logic [31:0]       old_word_s;
    logic [31:0]       new_word_s;
    uex_mem_rsp_t      push_data_s;

    logic [31:0]       mem_r [DEPTH];

    // Response FIFO interface and credit accounting.
    uex_mem_rsp_t      head_s;
    logic [CNT_W-1:0]  fifo_count_s;
    logic              rsp_valid_s;
    logic              pop_s;
    logic [CNT_W:0]    credit_s;
    logic              ready_nxt_s;

    assign accept_s = req_valid && req_ready_r;

    // Capture an accepted request into stage A.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            a_valid_r <= 1'b0;
            a_write_r <= 1'b0;
            a_size_r  <= SZ8;
            a_addr_r  <= ADDR_W'(0);
            a_wdata_r <= 32'h0000_0000;
        end else begin
            a_valid_r <= accept_s;
            if (accept_s) begin
                a_write_r <= req_write;
                a_size_r  <= uex_mem_size_e'(req_size);
                a_addr_r  <= req_addr;
                a_wdata_r <= req_wdata;
            end else begin
                a_write_r <= a_write_r;
                a_size_r  <= a_size_r;
                a_addr_r  <= a_addr_r;
                a_wdata_r <= a_wdata_r;
            end
        end
    end

    // Stage B: legality checks, lane merge for writes, lane extract for reads.
    always_comb begin
        off_s       = a_addr_r[1:0];
        word_idx_s  = a_addr_r[ADDR_W-1:2];
        mem_idx_s   = word_idx_s[IDX_W-1:0];
        oor_s       = (32'(word_idx_s) >= 32'(DEPTH));
        err_s       = uex_bad_align(a_size_r, off_s) || oor_s;
        old_word_s  = mem_r[mem_idx_s];
        new_word_s  = uex_lane_insert(old_word_s, a_wdata_r, a_size_r, off_s);
        wr_en_s     = a_valid_r && a_write_r && !err_s;
        push_data_s.rdata = (a_write_r || err_s) ? 32'h0000_0000
                                                 : uex_lane_extract(old_word_s, a_size_r, off_s);
        push_data_s.err   = err_s;
        push_data_s.write = a_write_r;
    end

    // Storage write port; a whole word is updated on a single edge so it cannot tear.
    always_ff @(posedge clock) begin
        if (wr_en_s) begin
            mem_r[mem_idx_s] <= new_word_s;
        end
    end

    uex_rsp_fifo #(
        .DEPTH     (RSP_DEPTH)
    ) u_rsp_fifo (
        .clock     (clock),
        .reset     (reset),
        .push      (a_valid_r),
        .push_data (push_data_s),
        .pop       (pop_s),
        .head      (head_s),
        .count     (fifo_count_s)
    );

    assign rsp_valid_s = (fifo_count_s != CNT_W'(0));
    assign pop_s       = rsp_valid_s && rsp_ready;

    // Next-cycle credit: occupancy after this edge plus whatever enters stage A.
    always_comb begin
        credit_s    = (CNT_W + 1)'(fifo_count_s) + (CNT_W + 1)'(a_valid_r)
                    - (CNT_W + 1)'(pop_s) + (CNT_W + 1)'(accept_s);
        ready_nxt_s = (credit_s < (CNT_W + 1)'(RSP_DEPTH));
    end

    // Registered request-ready so it never depends on req_valid in the same cycle.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            req_ready_r <= 1'b0;
        end else begin
            req_ready_r <= ready_nxt_s;
        end
    end

    assign req_ready = req_ready_r;
    assign rsp_valid = rsp_valid_s;
    assign rsp_rdata = rsp_valid_s ? head_s.rdata : 32'h0000_0000;
    assign rsp_err   = rsp_valid_s ? head_s.err   : 1'b0;
    assign rsp_write = rsp_valid_s ? head_s.write : 1'b0;

endmodule

// File: tb/tb_uex_mem_access_responder.sv
// Scoreboard bench for uex_mem_access_responder: the request driver pushes
// hand-computed expected responses, an independent monitor pops and compares.
module tb_uex_mem_access_responder;

    logic        clock;
    logic        reset;
    logic        req_valid;
    logic        req_ready;
    logic        req_write;
    logic [1:0]  req_size;
    logic [15:0] req_addr;
    logic [31:0] req_wdata;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_rdata;
    logic        rsp_err;
    logic        rsp_write;

    int          n_pass  = 0;
    int          n_total = 0;
    int          cyc     = 0;
    int          acc_cnt = 0;
    int          first_acc = -1;
    int          last_acc  = -1;
    int          first_rsp = -1;
    bit          measure   = 1'b0;
    int          base_acc;
    logic [33:0] exp_q [$];
    logic [33:0] mon_e;

    uex_mem_access_responder #(
        .ADDR_W    (16),
        .DEPTH     (1024),
        .RSP_DEPTH (4)
    ) dut (
        .clock     (clock),
        .reset     (reset),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_write (req_write),
        .req_size  (req_size),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_rdata (rsp_rdata),
        .rsp_err   (rsp_err),
        .rsp_write (rsp_write)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    always @(posedge clock) cyc <= cyc + 1;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    endtask

    // Present one request (called at posedge+1) and wait until it is accepted.
    task automatic send(input logic w, input logic [1:0] sz, input logic [15:0] a,
                        input logic [31:0] wd, input logic [31:0] er, input logic ee);
        bit ok;
        ok        = 1'b0;
        req_valid = 1'b1;
        req_write = w;
        req_size  = sz;
        req_addr  = a;
        req_wdata = wd;
        for (int k = 0; k < 200 && !ok; k++) begin
            @(negedge clock);
            if (req_ready) begin
                ok = 1'b1;
                exp_q.push_back({er, ee, w});
                acc_cnt++;
                if (measure && first_acc < 0) first_acc = cyc;
                last_acc = cyc;
            end
            @(posedge clock);
            #1;
        end
        if (!ok) begin
            n_total++;
            $display("FAIL accept_timeout: addr 0x%04h not accepted in 200 cycles, expected acceptance", a);
            req_valid = 1'b0;
        end
    endtask

    task automatic drain();
        for (int k = 0; k < 200 && exp_q.size() != 0; k++) @(posedge clock);
        if (exp_q.size() != 0) begin
            n_total++;
            $display("FAIL drain_timeout: %0d responses outstanding, expected 0", exp_q.size());
            exp_q.delete();
        end
        repeat (2) @(posedge clock);
        #1;
    endtask

    // Response monitor: compares every handshaken response with the scoreboard head.
    always @(negedge clock) begin
        if (measure && rsp_valid && first_rsp < 0) first_rsp = cyc;
        if (rsp_valid && rsp_ready) begin
            n_total++;
            if (exp_q.size() == 0) begin
                $display("FAIL rsp_unexpected: got rdata=0x%08h err=%0b write=%0b, expected no response",
                         rsp_rdata, rsp_err, rsp_write);
            end else begin
                mon_e = exp_q.pop_front();
                if ({rsp_rdata, rsp_err, rsp_write} === mon_e) n_pass++;
                else $display("FAIL rsp_data: got rdata=0x%08h err=%0b write=%0b, expected rdata=0x%08h err=%0b write=%0b",
                              rsp_rdata, rsp_err, rsp_write, mon_e[33:2], mon_e[1], mon_e[0]);
            end
        end
    end

    initial begin
        reset     = 1'b1;
        req_valid = 1'b0;
        req_write = 1'b0;
        req_size  = 2'd0;
        req_addr  = 16'h0000;
        req_wdata = 32'h0000_0000;
        rsp_ready = 1'b1;

        // Reset values
        #3;
        chk("reset_req_ready", 32'(req_ready), 32'd0);
        chk("reset_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("reset_rsp_rdata", rsp_rdata, 32'h0);
        chk("reset_rsp_err",   32'(rsp_err), 32'd0);
        chk("reset_rsp_write", 32'(rsp_write), 32'd0);
        @(posedge clock); #1;
        reset = 1'b0;
        @(posedge clock); #1;
        chk("post_reset_req_ready", 32'(req_ready), 32'd1);

        // Basic writes/reads and lane handling
        send(1'b1, 2'd2, 16'h0000, 32'h0BAD_F00D, 32'h0, 1'b0);
        send(1'b1, 2'd2, 16'h0010, 32'hDEAD_BEEF, 32'h0, 1'b0);
        send(1'b0, 2'd2, 16'h0010, 32'h0, 32'hDEAD_BEEF, 1'b0);
        send(1'b1, 2'd0, 16'h0013, 32'h0000_005A, 32'h0, 1'b0);
        send(1'b0, 2'd1, 16'h0012, 32'h0, 32'h0000_5AAD, 1'b0);
        send(1'b0, 2'd0, 16'h0011, 32'h0, 32'h0000_00BE, 1'b0);
        send(1'b0, 2'd1, 16'h0010, 32'h0, 32'h0000_BEEF, 1'b0);
        send(1'b0, 2'd0, 16'h0013, 32'h0, 32'h0000_005A, 1'b0);
        send(1'b1, 2'd2, 16'h0FFC, 32'h1234_5678, 32'h0, 1'b0);
        send(1'b0, 2'd2, 16'h0FFC, 32'h0, 32'h1234_5678, 1'b0);

        // Illegal requests leave storage untouched
        send(1'b1, 2'd1, 16'h0011, 32'h0000_FFFF, 32'h0, 1'b1);
        send(1'b1, 2'd2, 16'h0012, 32'hFFFF_FFFF, 32'h0, 1'b1);
        send(1'b1, 2'd3, 16'h0010, 32'hFFFF_FFFF, 32'h0, 1'b1);
        send(1'b1, 2'd2, 16'h1000, 32'hFFFF_FFFF, 32'h0, 1'b1);
        send(1'b0, 2'd2, 16'h0012, 32'h0, 32'h0, 1'b1);
        send(1'b0, 2'd2, 16'h0010, 32'h0, 32'h5AAD_BEEF, 1'b0);
        send(1'b0, 2'd2, 16'h0000, 32'h0, 32'h0BAD_F00D, 1'b0);
        send(1'b1, 2'd1, 16'h0002, 32'h0000_CAFE, 32'h0, 1'b0);
        send(1'b0, 2'd2, 16'h0000, 32'h0, 32'hCAFE_F00D, 1'b0);
        req_valid = 1'b0;
        drain();

        // Back-pressure: four accepted, then req_ready drops until the FIFO drains
        for (int i = 0; i < 6; i++)
            send(1'b1, 2'd2, 16'h0020 + 16'(4 * i), 32'hA000_0000 + 32'(i), 32'h0, 1'b0);
        req_valid = 1'b0;
        drain();
        rsp_ready = 1'b0;
        base_acc  = acc_cnt;
        fork
            begin
                for (int i = 0; i < 6; i++)
                    send(1'b0, 2'd2, 16'h0020 + 16'(4 * i), 32'h0, 32'hA000_0000 + 32'(i), 1'b0);
                req_valid = 1'b0;
            end
            begin
                repeat (10) @(negedge clock);
                chk("bp_accepted", 32'(acc_cnt - base_acc), 32'd4);
                chk("bp_req_ready", 32'(req_ready), 32'd0);
                chk("bp_rsp_valid", 32'(rsp_valid), 32'd1);
                @(posedge clock); #1;
                rsp_ready = 1'b1;
            end
        join
        chk("bp_total_accepted", 32'(acc_cnt - base_acc), 32'd6);
        drain();

        // Streaming: 16 back-to-back requests, write then read of each word
        measure   = 1'b1;
        first_acc = -1;
        first_rsp = -1;
        for (int i = 0; i < 8; i++) begin
            send(1'b1, 2'd2, 16'h0040 + 16'(4 * i), 32'hC0DE_0000 + 32'(i), 32'h0, 1'b0);
            send(1'b0, 2'd2, 16'h0040 + 16'(4 * i), 32'h0, 32'hC0DE_0000 + 32'(i), 1'b0);
        end
        req_valid = 1'b0;
        drain();
        measure = 1'b0;
        chk("stream_latency", 32'(first_rsp - first_acc), 32'd2);
        chk("stream_accept_span", 32'(last_acc - first_acc), 32'd15);

        // Reset with three responses queued
        rsp_ready = 1'b0;
        for (int i = 0; i < 3; i++)
            send(1'b0, 2'd2, 16'h0020 + 16'(4 * i), 32'h0, 32'hA000_0000 + 32'(i), 1'b0);
        req_valid = 1'b0;
        repeat (4) @(posedge clock);
        @(negedge clock);
        chk("pre_reset_rsp_valid", 32'(rsp_valid), 32'd1);
        #2;
        reset = 1'b1;
        #1;
        chk("async_reset_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("async_reset_rsp_rdata", rsp_rdata, 32'h0);
        chk("async_reset_req_ready", 32'(req_ready), 32'd0);
        exp_q.delete();
        @(posedge clock); #1;
        rsp_ready = 1'b1;
        @(posedge clock); #1;
        reset = 1'b0;
        @(posedge clock); #1;
        chk("after_reset_req_ready", 32'(req_ready), 32'd1);
        chk("after_reset_rsp_valid", 32'(rsp_valid), 32'd0);
        repeat (6) @(posedge clock);
        #1;
        send(1'b0, 2'd2, 16'h0010, 32'h0, 32'h5AAD_BEEF, 1'b0);
        req_valid = 1'b0;
        drain();

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
